// File: rtl/ft_pkg.sv
// Shared definitions for the FT2232H synchronous FIFO receive path.
package ft_pkg;

   localparam int unsigned FT_DATA_W = 8;

   typedef enum logic [1:0] {
      StIdle,
      StTurn,
      StRead
   } ft_state_e;

endpackage

// File: rtl/ft_byte_fifo.sv
// Synchronous byte FIFO with a registered first-word-fall-through head.
module ft_byte_fifo import ft_pkg::*; #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4
) (
   input  logic                 clk_i,
   input  logic                 rdreset,
   input  logic                 push_i,
   input  logic [FT_DATA_W-1:0] wdata_i,
   input  logic                 pop_i,
   output logic                 full_o,
   output logic                 empty_o,
   output logic [AW:0]          level_o,
   output logic [FT_DATA_W-1:0] head_o
);

   logic [AW:0]          wr_ptr_q, wr_ptr_d;
   logic [AW:0]          rd_ptr_q, rd_ptr_d;
   logic [FT_DATA_W-1:0] mem_q [DEPTH];
   logic [FT_DATA_W-1:0] head_q, head_d;
   logic                 full, empty, wr_en, rd_en;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign rd_en = pop_i && !empty;
   // A pop in the same cycle frees the slot, so a push at full is still accepted.
   assign wr_en = push_i && (!full || rd_en);

   always_comb begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(wr_en);
      rd_ptr_d = rd_ptr_q + (AW+1)'(rd_en);
      head_d   = head_q;
      if (rd_ptr_d != wr_ptr_d) begin
         // New head is the byte being written this cycle: bypass the memory.
         if (wr_en && (rd_ptr_d == wr_ptr_q)) head_d = wdata_i;
         else                                 head_d = mem_q[rd_ptr_d[AW-1:0]];
      end
   end

   always_ff @(posedge clk_i or posedge rdreset) begin
      if (rdreset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         head_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         head_q   <= head_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
   end

   assign full_o  = full;
   assign empty_o = empty;
   assign level_o = wr_ptr_q - rd_ptr_q;
   assign head_o  = head_q;

endmodule

// File: rtl/ft_sync_rx_ctrl.sv
// FT2232H 245 synchronous FIFO receive controller: drains host bytes into a local FIFO
// and presents them as a valid/ready stream.
module ft_sync_rx_ctrl import ft_pkg::*; #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4
) (
   input  logic                 clkout_i,
   input  logic                 rdreset,
   input  logic                 rxf_n_i,
   input  logic [FT_DATA_W-1:0] data_i,
   output logic                 oe_n_o,
   output logic                 rd_n_o,
   output logic [FT_DATA_W-1:0] m_data_o,
   output logic                 m_valid_o,
   input  logic                 m_ready_i,
   output logic [AW:0]          level_o,
   output logic                 ovf_o
);

   // Two-byte margin absorbs the byte strobed while rd_n is still registered low.
   localparam logic [AW:0] AfullLvl = (AW+1)'(DEPTH - 2);

   ft_state_e   state_q, state_d;
   logic        oe_n_q, oe_n_d;
   logic        rd_n_q, rd_n_d;
   logic        ovf_q, ovf_d;
   logic [AW:0] level;
   logic        full, empty, afull, capture, pop;

   assign afull   = (level >= AfullLvl);
   assign capture = !rd_n_q && !rxf_n_i;
   assign pop     = !empty && m_ready_i;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (!rxf_n_i && !afull) state_d = StTurn;
         StTurn: begin
            if (rxf_n_i || afull) state_d = StIdle;
            else                  state_d = StRead;
         end
         StRead: if (rxf_n_i || afull) state_d = StIdle;
         default: state_d = StIdle;
      endcase
      oe_n_d = (state_d == StIdle);
      rd_n_d = (state_d != StRead);
      ovf_d  = ovf_q | (capture & full & !pop);
   end

   always_ff @(posedge clkout_i or posedge rdreset) begin
      if (rdreset) begin
         state_q <= StIdle;
         oe_n_q  <= 1'b1;
         rd_n_q  <= 1'b1;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         oe_n_q  <= oe_n_d;
         rd_n_q  <= rd_n_d;
         ovf_q   <= ovf_d;
      end
   end

   ft_byte_fifo #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fifo (
      .clk_i   (clkout_i),
      .rdreset (rdreset),
      .push_i  (capture),
      .wdata_i (data_i),
      .pop_i   (pop),
      .full_o  (full),
      .empty_o (empty),
      .level_o (level),
      .head_o  (m_data_o)
   );

   assign oe_n_o    = oe_n_q;
   assign rd_n_o    = rd_n_q;
   assign m_valid_o = !empty;
   assign level_o   = level;
   assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_ft_sync_rx_ctrl.sv
// Directed bench for ft_sync_rx_ctrl: cycle vector table plus FT2232H-model sequences.
module tb_ft_sync_rx_ctrl;

   logic       clk = 1'b0;
   logic       rdreset;
   logic       rxf_n_i;
   logic [7:0] data_i;
   logic       oe_n_o, rd_n_o;
   logic [7:0] m_data_o;
   logic       m_valid_o;
   logic       m_ready_i;
   logic [4:0] level_o;
   logic       ovf_o;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] ft_q[$];
   logic [7:0] rx_q[$];

   typedef struct {
      logic       rxf_n;
      logic [7:0] data;
      logic       ready;
      logic       oe_n;
      logic       rd_n;
      logic       valid;
      logic [7:0] mdata;
      logic [4:0] level;
   } vec_t;

   vec_t vecs[16];

   always #8 clk = ~clk;

   ft_sync_rx_ctrl #(
      .DEPTH (16),
      .AW    (4)
   ) dut (
      .clkout_i  (clk),
      .rdreset   (rdreset),
      .rxf_n_i   (rxf_n_i),
      .data_i    (data_i),
      .oe_n_o    (oe_n_o),
      .rd_n_o    (rd_n_o),
      .m_data_o  (m_data_o),
      .m_valid_o (m_valid_o),
      .m_ready_i (m_ready_i),
      .level_o   (level_o),
      .ovf_o     (ovf_o)
   );

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One clock of the FT2232H model plus stream sink; returns #1 after the edge.
   task automatic ft_cycle();
      logic       cap, popped;
      logic [7:0] pdata;
      rxf_n_i = (ft_q.size() == 0);
      data_i  = (ft_q.size() != 0) ? ft_q[0] : 8'h00;
      cap     = !rd_n_o && !rxf_n_i;
      popped  = m_valid_o && m_ready_i;
      pdata   = m_data_o;
      @(posedge clk);
      #1;
      if (cap) void'(ft_q.pop_front());
      if (popped) rx_q.push_back(pdata);
   endtask

   initial begin
      int max_lvl;

      vecs[0]  = '{1'b0, 8'hA1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 5'd0};
      vecs[1]  = '{1'b0, 8'hA1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0};
      vecs[2]  = '{1'b0, 8'hA1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA1, 5'd1};
      vecs[3]  = '{1'b0, 8'hA2, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA2, 5'd1};
      vecs[4]  = '{1'b0, 8'hA3, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA3, 5'd1};
      vecs[5]  = '{1'b0, 8'hA4, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA4, 5'd1};
      vecs[6]  = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 5'd0};
      vecs[7]  = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 5'd0};
      vecs[8]  = '{1'b0, 8'h5B, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 5'd0};
      vecs[9]  = '{1'b0, 8'h5B, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0};
      vecs[10] = '{1'b0, 8'h5B, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5B, 5'd1};
      vecs[11] = '{1'b0, 8'h6C, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5B, 5'd2};
      vecs[12] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h5B, 5'd2};
      vecs[13] = '{1'b0, 8'h7D, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5B, 5'd2};
      vecs[14] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h6C, 5'd1};
      vecs[15] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 5'd0};

      rdreset   = 1'b1;
      rxf_n_i   = 1'b1;
      data_i    = 8'h00;
      m_ready_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset oe_n/rd_n", int'({oe_n_o, rd_n_o}), 3);
      check("reset m_valid", int'(m_valid_o), 0);
      check("reset m_data", int'(m_data_o), 0);
      check("reset level", int'(level_o), 0);
      check("reset ovf", int'(ovf_o), 0);
      rdreset = 1'b0;

      // Burst of four with streaming sink, then short burst interrupted by rxf_n.
      for (int i = 0; i < 16; i++) begin
         rxf_n_i   = vecs[i].rxf_n;
         data_i    = vecs[i].data;
         m_ready_i = vecs[i].ready;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d oe_n/rd_n", i), int'({oe_n_o, rd_n_o}),
               int'({vecs[i].oe_n, vecs[i].rd_n}));
         check($sformatf("vec%0d m_valid", i), int'(m_valid_o), int'(vecs[i].valid));
         check($sformatf("vec%0d level", i), int'(level_o), int'(vecs[i].level));
         if (vecs[i].valid)
            check($sformatf("vec%0d m_data", i), int'(m_data_o), int'(vecs[i].mdata));
      end

      // Back-pressure: 40 bytes with sink stalled, read stops at the almost-full mark.
      rx_q.delete();
      for (int i = 0; i < 40; i++) ft_q.push_back(8'(8'h40 + i));
      m_ready_i = 1'b0;
      max_lvl   = 0;
      for (int c = 0; c < 30; c++) begin
         ft_cycle();
         if (int'(level_o) > max_lvl) max_lvl = int'(level_o);
      end
      check("stall level", int'(level_o), 15);
      check("stall rd_n", int'(rd_n_o), 1);
      check("stall oe_n", int'(oe_n_o), 1);
      check("stall max level <= 16", int'(max_lvl <= 16), 1);
      check("stall ovf", int'(ovf_o), 0);
      check("stall ft remaining", ft_q.size(), 25);
      m_ready_i = 1'b1;
      for (int c = 0; c < 400 && rx_q.size() < 40; c++) ft_cycle();
      check("stall bytes delivered", rx_q.size(), 40);
      for (int i = 0; i < rx_q.size() && i < 40; i++)
         check($sformatf("stall byte %0d", i), int'(rx_q[i]), (8'h40 + i) & 8'hFF);
      check("stall ovf after drain", int'(ovf_o), 0);
      ft_cycle();
      check("stall level after drain", int'(level_o), 0);

      // Sink toggling ready every cycle during a 32-byte burst.
      rx_q.delete();
      ft_q.delete();
      for (int i = 0; i < 32; i++) ft_q.push_back(8'(i));
      m_ready_i = 1'b0;
      for (int c = 0; c < 400 && rx_q.size() < 32; c++) begin
         m_ready_i = ~m_ready_i;
         ft_cycle();
      end
      check("toggle bytes delivered", rx_q.size(), 32);
      for (int i = 0; i < rx_q.size() && i < 32; i++)
         check($sformatf("toggle byte %0d", i), int'(rx_q[i]), i);
      check("toggle ovf", int'(ovf_o), 0);

      // Defeat almost-full so the controller strobes into a full FIFO.
      m_ready_i = 1'b1;
      for (int c = 0; c < 5; c++) ft_cycle();
      rx_q.delete();
      ft_q.delete();
      for (int i = 0; i < 20; i++) ft_q.push_back(8'(8'h80 + i));
      m_ready_i = 1'b0;
      force dut.afull = 1'b0;
      for (int c = 0; c < 25; c++) ft_cycle();
      check("full level", int'(level_o), 16);
      check("full ovf set", int'(ovf_o), 1);
      check("full head", int'(m_data_o), 8'h80);
      release dut.afull;
      for (int c = 0; c < 3; c++) ft_cycle();
      check("ovf sticky idle", int'(ovf_o), 1);
      m_ready_i = 1'b1;
      for (int c = 0; c < 40 && rx_q.size() < 16; c++) ft_cycle();
      check("full bytes kept", rx_q.size(), 16);
      for (int i = 0; i < rx_q.size() && i < 16; i++)
         check($sformatf("full byte %0d", i), int'(rx_q[i]), 8'h80 + i);
      check("ovf sticky after drain", int'(ovf_o), 1);
      rdreset = 1'b1;
      #1;
      check("ovf cleared by reset", int'(ovf_o), 0);
      @(posedge clk);
      #1;
      rdreset = 1'b0;

      // Asynchronous reset while reading with three bytes buffered.
      rx_q.delete();
      ft_q.delete();
      for (int i = 0; i < 10; i++) ft_q.push_back(8'(8'hC0 + i));
      m_ready_i = 1'b0;
      for (int c = 0; c < 20 && level_o != 5'd3; c++) ft_cycle();
      check("pre-reset level", int'(level_o), 3);
      check("pre-reset rd_n", int'(rd_n_o), 0);
      rdreset = 1'b1;
      #1;
      check("async reset oe_n/rd_n", int'({oe_n_o, rd_n_o}), 3);
      check("async reset m_valid", int'(m_valid_o), 0);
      check("async reset level", int'(level_o), 0);
      ft_q.delete();
      rxf_n_i = 1'b1;
      @(posedge clk);
      #1;
      rdreset = 1'b0;
      ft_cycle();
      check("post-reset idle", int'({oe_n_o, rd_n_o, m_valid_o}), 6);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
